singlepath_seq_spy: RTL and testbench
=====================================

SINGLEPATH_SEQ_SPY -- requirements
Module: singlepath_seq_spy

Interface
REQ-001 Parameter PATH_LEN, default 32, number of buffered inverting path stages; SHALL be even and at least 2.
REQ-002 Parameter TRIG_COUNT, default 16, number of qualified trigger events required to fire; SHALL be in the range 1 to 2^CNT_W-1.
REQ-003 Parameter CNT_W, default 8, width of the trigger-event counter.
REQ-004 Parameter MODE, default 1: 0 = combinational trigger, 1 = sequential counting trigger.
REQ-005 clk  input  1  single clock for all registers.
REQ-006 rst_n  input  1  reset, synchronous to clk, active-low.
REQ-007 Vcc  input  1  constant-1 tie used as the second operand of path gates.
REQ-008 gnd  input  1  constant-0 tie used as the second operand of path gates.
REQ-009 path_in  input  1  launch data into the delay path.
REQ-010 ht_in1  input  1  trigger condition input A.
REQ-011 ht_in2  input  1  trigger condition input B.
REQ-012 arm  input  1  enables trigger event counting.
REQ-013 clear  input  1  returns the trigger FSM to IDLE and zeroes the counter.
REQ-014 path_out  output  1  captured path output, registered.
REQ-015 trig_active  output  1  payload currently applied.
REQ-016 trig_cnt  output  CNT_W  current qualified-event count.

Function
REQ-017 path_in SHALL be registered into a launch flop.
REQ-018 The launch flop SHALL feed PATH_LEN combinational stages alternating NAND-with-Vcc and NOT, with one keep attribute per stage net so that synthesis does not collapse the path.
REQ-019 The payload SHALL be path_end XOR trig_active, inserted after stage PATH_LEN/2.
REQ-020 The path result SHALL be registered into the capture flop that drives path_out.
REQ-021 With trig_active=0, path_out SHALL equal path_in delayed exactly 2 cycles, non-inverted.
REQ-022 With trig_active=1, path_out SHALL equal the inverted path_in delayed 2 cycles.
REQ-023 Qualified event: a rising edge of ev = ht_in1 AND ht_in2, detected against the registered previous value of ev; a level held high SHALL count once.
REQ-024 When MODE=0, trig_active SHALL be the registered value of ev, independent of arm; the FSM and counter SHALL be held in IDLE/0.
REQ-025 When MODE=1, the FSM SHALL have the states IDLE, COUNT and FIRED.
REQ-026 IDLE -> COUNT when arm=1; trig_cnt SHALL stay 0.
REQ-027 COUNT: each qualified event SHALL increment trig_cnt by 1.
REQ-028 COUNT -> FIRED in the cycle the increment makes trig_cnt equal TRIG_COUNT.
REQ-029 COUNT -> IDLE when arm=0; trig_cnt SHALL reset to 0 in that transition.
REQ-030 FIRED SHALL be sticky; arm and further events SHALL be ignored and trig_cnt SHALL hold at TRIG_COUNT.
REQ-031 trig_active SHALL be 1 exactly while the state is FIRED (registered, no combinational path from inputs).
REQ-032 clear=1 in any state SHALL force IDLE and trig_cnt=0 on the next edge.
REQ-033 clear SHALL take priority over a simultaneous event, arm, or firing increment.
REQ-034 An event in the same cycle as the IDLE->COUNT transition SHALL NOT be counted.
REQ-035 trig_cnt SHALL never wrap; the increment SHALL be suppressed once trig_cnt equals TRIG_COUNT.

Reset
REQ-036 When rst_n=0 at a clk edge, the launch flop, capture flop, ev history, trig_cnt, FSM and trig_active SHALL clear: path_out=0, trig_cnt=0, trig_active=0, state IDLE.
REQ-037 A reset asserted mid-COUNT or in FIRED SHALL discard all progress; counting SHALL restart from 0 after arm is re-seen.

Verification
REQ-038 MODE=1, TRIG_COUNT=3, arm=1, path_in toggling, no events -> path_out = path_in delayed 2 cycles; trig_active=0; trig_cnt=0.
REQ-039 Three ev pulses, 1 cycle each, spaced 2 cycles apart -> trig_cnt 1,2,3; FIRED the cycle after the 3rd edge; path_out inverted 2 cycles later.
REQ-040 ev held high for 10 cycles -> trig_cnt=1 only.
REQ-041 trig_cnt=2, then arm=0 -> IDLE, trig_cnt=0; re-arm and 3 events -> fires.
REQ-042 clear and the 3rd event in the same cycle -> IDLE, trig_cnt=0, trig_active stays 0.
REQ-043 MODE=0: ht_in1=ht_in2=1 -> trig_active=1 the next cycle; rst_n=0 in FIRED -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/singlepath_seq_spy.sv
// -----------------------------------------------------------------------------
// singlepath_seq_spy
//
// A registered launch flop drives a long chain of inverting gates that ends in
// a capture flop. A payload XOR sits at the midpoint of the chain. When the
// trigger is active, the payload inverts the captured data. The trigger is
// either the registered AND of two condition inputs (MODE=0), or a sticky
// counting FSM (MODE=1). The FSM fires after TRIG_COUNT rising edges of that
// AND while it is armed.
//
// Ports
//   clk          single clock for every register
//   rst_n        synchronous active-low reset
//   Vcc, gnd     constant ties used as gate operands in the path
//   path_in      data launched into the path
//   ht_in1/2     trigger condition inputs (event = ht_in1 & ht_in2)
//   arm          enables event counting (MODE=1)
//   clear        forces the FSM to IDLE and zeroes the counter
//   path_out     captured path result (registered)
//   trig_active  payload applied (registered)
//   trig_cnt     qualified-event count (registered)
// -----------------------------------------------------------------------------
module singlepath_seq_spy #(
  parameter int PATH_LEN   = 32,
  parameter int TRIG_COUNT = 16,
  parameter int CNT_W      = 8,
  parameter int MODE       = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Vcc,
  input  logic             gnd,
  input  logic             path_in,
  input  logic             ht_in1,
  input  logic             ht_in2,
  input  logic             arm,
  input  logic             clear,
  output logic             path_out,
  output logic             trig_active,
  output logic [CNT_W-1:0] trig_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_FIRED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_TRIG = CNT_W'(TRIG_COUNT);

  logic             r_launch;
  logic             r_capture;
  logic             r_ev_prev;
  logic             r_trig_active;
  logic [CNT_W-1:0] r_cnt;
  state_t           r_state;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_trig_nxt;
  logic             w_ev;
  logic             w_rise;
  logic             w_unused_gnd;

  // Links between stages: w_link[0] is the launch flop and w_link[PATH_LEN] is the path end.
  logic             w_link [0:PATH_LEN];

  // gnd is a tie that the gate chain does not need.
  assign w_unused_gnd = gnd;

  assign w_link[0] = r_launch;

  // Gate chain. Even-indexed stages are NAND-with-Vcc and odd-indexed stages
  // are NOT. PATH_LEN is even, so the chain inverts an even number of times
  // and is non-inverting overall. The payload XOR sits at the input of stage
  // PATH_LEN/2, which is the output of the first half of the chain.
  for (genvar g = 0; g < PATH_LEN; g++) begin : g_stage
    (* keep = "true" *) logic w_net;
    logic w_in;

    if (g == PATH_LEN / 2) begin : g_payload
      assign w_in = w_link[g] ^ r_trig_active;
    end else begin : g_plain
      assign w_in = w_link[g];
    end

    if ((g % 2) == 0) begin : g_nand
      assign w_net = ~(w_in & Vcc);
    end else begin : g_not
      assign w_net = ~w_in;
    end

    assign w_link[g+1] = w_net;
  end

  // Level-held events count once, so only a 0->1 change of ev qualifies.
  assign w_ev      = ht_in1 & ht_in2;
  assign w_rise    = w_ev & ~r_ev_prev;
  assign w_cnt_inc = r_cnt + CNT_W'(1'b1);

  // Trigger next-state, next-count and next-payload logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_trig_nxt  = 1'b0;
    if (MODE == 0) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = {CNT_W{1'b0}};
      w_trig_nxt  = w_ev;
    end else begin
      if (clear) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end else begin
        case (r_state)
          S_IDLE: begin
            // An event during the arming cycle is not counted.
            w_cnt_nxt = {CNT_W{1'b0}};
            if (arm) begin
              w_state_nxt = S_COUNT;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
          S_COUNT: begin
            if (!arm) begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = {CNT_W{1'b0}};
            end else if (w_rise && (r_cnt != LP_TRIG)) begin
              w_cnt_nxt = w_cnt_inc;
              if (w_cnt_inc == LP_TRIG) begin
                w_state_nxt = S_FIRED;
              end else begin
                w_state_nxt = S_COUNT;
              end
            end else begin
              w_state_nxt = S_COUNT;
            end
          end
          S_FIRED: begin
            // Sticky until clear or reset.
            w_state_nxt = S_FIRED;
            w_cnt_nxt   = LP_TRIG;
          end
          default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = {CNT_W{1'b0}};
          end
        endcase
      end
      // Registering this makes trig_active track the FIRED state exactly.
      w_trig_nxt = (w_state_nxt == S_FIRED);
    end
  end

  // Launch/capture flops, event history, FSM state, counter and payload enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_launch      <= 1'b0;
      r_capture     <= 1'b0;
      r_ev_prev     <= 1'b0;
      r_trig_active <= 1'b0;
      r_cnt         <= {CNT_W{1'b0}};
      r_state       <= S_IDLE;
    end else begin
      r_launch      <= path_in;
      r_capture     <= w_link[PATH_LEN];
      r_ev_prev     <= w_ev;
      r_trig_active <= w_trig_nxt;
      r_cnt         <= w_cnt_nxt;
      r_state       <= w_state_nxt;
    end
  end

  assign path_out    = r_capture;
  assign trig_active = r_trig_active;
  assign trig_cnt    = r_cnt;

endmodule

// File: tb/tb_singlepath_seq_spy.sv
// -----------------------------------------------------------------------------
// Testbench for singlepath_seq_spy.
//
// Two instances share all inputs. dut1 uses MODE=1 with TRIG_COUNT=3, and
// dut0 uses MODE=0. The driver applies inputs on the falling edge and pushes
// the expected post-edge outputs of both instances into a queue. The
// expectations come from a behavioural model that tracks "armed", "fired" and
// "count". The monitor pops one entry after every rising edge and compares it
// with the outputs.
// -----------------------------------------------------------------------------
module tb_singlepath_seq_spy;

  localparam int CW = 8;
  localparam int TC = 3;

  typedef struct packed {
    logic          out1;
    logic          trig1;
    logic [CW-1:0] cnt1;
    logic          out0;
    logic          trig0;
    logic [CW-1:0] cnt0;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          Vcc = 1'b1;
  logic          gnd = 1'b0;
  logic          path_in = 1'b0;
  logic          ht_in1 = 1'b0;
  logic          ht_in2 = 1'b0;
  logic          arm = 1'b0;
  logic          clear = 1'b0;
  logic          out1, trig1, out0, trig0;
  logic [CW-1:0] cnt1, cnt0;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Model state.
  bit m_launch, m_out1, m_out0, m_trig1, m_trig0, m_prev, m_counting, m_fired;
  int m_cnt;

  singlepath_seq_spy #(.PATH_LEN(32), .TRIG_COUNT(TC), .CNT_W(CW), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .Vcc(Vcc), .gnd(gnd), .path_in(path_in),
    .ht_in1(ht_in1), .ht_in2(ht_in2), .arm(arm), .clear(clear),
    .path_out(out1), .trig_active(trig1), .trig_cnt(cnt1)
  );

  singlepath_seq_spy #(.PATH_LEN(32), .TRIG_COUNT(TC), .CNT_W(CW), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .Vcc(Vcc), .gnd(gnd), .path_in(path_in),
    .ht_in1(ht_in1), .ht_in2(ht_in2), .arm(arm), .clear(clear),
    .path_out(out0), .trig_active(trig0), .trig_cnt(cnt0)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Drive one cycle of inputs, advance the model across the next rising edge
  // and queue the outputs expected after that edge.
  task automatic step(input bit rn, input bit clr, input bit a, input bit h1, input bit h2, input bit p);
    exp_t e;
    bit   ev;
    bit   rise;
    @(negedge clk);
    rst_n = rn; clear = clr; arm = a; ht_in1 = h1; ht_in2 = h2; path_in = p;
    ev = h1 & h2;
    if (!rn) begin
      m_launch = 0; m_out1 = 0; m_out0 = 0; m_trig1 = 0; m_trig0 = 0;
      m_prev = 0; m_counting = 0; m_fired = 0; m_cnt = 0;
    end else begin
      // Captured data = launched bit, inverted if the payload was on in between.
      m_out1 = m_launch ^ m_trig1;
      m_out0 = m_launch ^ m_trig0;
      m_launch = p;
      m_trig0 = ev;
      rise = ev && !m_prev;
      if (clr) begin
        m_counting = 0; m_fired = 0; m_cnt = 0;
      end else if (m_fired) begin
        m_cnt = TC;
      end else if (!m_counting) begin
        m_counting = a;
      end else if (!a) begin
        m_counting = 0; m_cnt = 0;
      end else if (rise) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == TC) m_fired = 1;
      end
      m_trig1 = m_fired;
      m_prev = ev;
    end
    e.out1 = m_out1; e.trig1 = m_trig1; e.cnt1 = CW'(m_cnt);
    e.out0 = m_out0; e.trig0 = m_trig0; e.cnt0 = '0;
    q.push_back(e);
  endtask

  // Wait until after the edge that applies the last step, for directed checks.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse(input bit a);
    step(1, 0, a, 1, 1, 1'($urandom));
    step(1, 0, a, 0, 1, 1'($urandom));
  endtask

  // Monitor: compare every post-edge output with the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("path_out1", CW'(out1), CW'(e.out1));
        check("trig_active1", CW'(trig1), CW'(e.trig1));
        check("trig_cnt1", cnt1, e.cnt1);
        check("path_out0", CW'(out0), CW'(e.out0));
        check("trig_active0", CW'(trig0), CW'(e.trig0));
        check("trig_cnt0", cnt0, e.cnt0);
      end
    end
  end

  // Stimulus.
  initial begin
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1, 1);
    settle();
    check("reset_out", CW'(out1), CW'(1'b0));
    check("reset_cnt", cnt1, CW'(0));

    // Armed, no events: plain 2-cycle delay.
    for (int i = 0; i < 12; i++) step(1, 0, 1, 0, 1'($urandom), 1'($urandom));

    // Three spaced pulses fire the trigger.
    for (int i = 0; i < 3; i++) pulse(1);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0, 1'($urandom));
    settle();
    check("fire_trig", CW'(trig1), CW'(1'b1));
    check("fire_cnt", cnt1, CW'(TC));

    // A held level counts once.
    step(1, 1, 1, 0, 0, 1);
    step(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 1, 1, 1, 1'($urandom));
    step(1, 0, 1, 0, 0, 1);
    settle();
    check("held_cnt", cnt1, CW'(1));

    // Reach a count of 2, then disarm, re-arm and fire.
    pulse(1);
    step(1, 0, 0, 0, 0, 0);
    settle();
    check("disarm_cnt", cnt1, CW'(0));
    step(1, 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) pulse(1);
    settle();
    check("rearm_trig", CW'(trig1), CW'(1'b1));

    // clear wins over the third event.
    step(1, 1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 1);
    pulse(1);
    pulse(1);
    step(1, 1, 1, 1, 1, 1);
    settle();
    check("clear_cnt", cnt1, CW'(0));
    check("clear_trig", CW'(trig1), CW'(1'b0));
    check("mode0_trig", CW'(trig0), CW'(1'b1));

    // Fire again, then reset while FIRED.
    step(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) pulse(1);
    step(0, 0, 1, 1, 1, 1);
    settle();
    check("rst_fired_trig", CW'(trig1), CW'(1'b0));
    check("rst_fired_out", CW'(out1), CW'(1'b0));

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 9) != 0), 1'($urandom), ($urandom_range(0, 3) != 0),
           1'($urandom));
    end

    settle();
    settle();
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
